// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding, slice width, overflow helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package nibble_serial_adder_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Width of the single CLA slice the word is streamed through
    localparam int NIBBLE_W = 4;

    // Two's-complement overflow: operands share a sign and the result sign differs
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead adder slice, reused one nibble per clock by the serial adder.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module CLA_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Lookahead carries, each expanded directly from Cin rather than rippled
    always_comb begin
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
    end

    assign sum  = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands LSB-nibble-first through one 4-bit CLA slice.
// Latency: accept at edge 0, out_valid after edge NIB; one op per NIB+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no drain+accept in one cycle.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    logic [1:0]              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [WIDTH-1:0]        a_sh;
    logic [WIDTH-1:0]        b_sh;
    // Completed low nibbles; the final nibble is appended on the way into sum
    logic [WIDTH-NIBBLE_W-1:0] res_sh;
    logic                    carry_q;
    logic                    a_msb_q;
    logic                    b_msb_q;

    logic [NIBBLE_W-1:0]     nib_sum;
    logic                    nib_cout;
    logic                    accept;
    logic                    drain;
    logic                    last_nib;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_nib  = (state_q == ADD) && (cnt_q == LAST_NIB);

    CLA_adder u_cla (
        .A    (a_sh[NIBBLE_W-1:0]),
        .B    (b_sh[NIBBLE_W-1:0]),
        .Cin  (carry_q),
        .sum  (nib_sum),
        .Cout (nib_cout)
    );

    // FSM: IDLE -> ADD on accept, ADD -> DONE after the last nibble, DONE -> IDLE on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept)   state_q <= ADD;
                ADD:     if (last_nib) state_q <= DONE;
                DONE:    if (drain)    state_q <= IDLE;
                default:               state_q <= IDLE;
            endcase
        end
    end

    // Operand shift registers, carry chain register, nibble counter and partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == ADD) begin
            a_sh    <= a_sh >> NIBBLE_W;
            b_sh    <= b_sh >> NIBBLE_W;
            res_sh  <= {nib_sum, res_sh[WIDTH-NIBBLE_W-1:NIBBLE_W]};
            carry_q <= nib_cout;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Result registers load only on the final nibble so they stay frozen outside DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_nib) begin
            sum  <= {nib_sum, res_sh};
            cout <= nib_cout;
            ovf  <= signed_ovf(a_msb_q, b_msb_q, nib_sum[NIBBLE_W-1]);
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
// Latency: checks out_valid lands exactly 4 edges after accept.
// Backpressure: exercises held results, back-to-back in_valid and mid-operation reset.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks;
    int errors;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] es, input logic ec,
                          input logic eo, input int hold);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        @(negedge clk);                      // accepted on the edge just passed
        in_valid = 1'b0;
        a = 16'hDEAD;                        // must be ignored during ADD
        b = 16'hBEEF;
        cin = 1'b1;
        out_ready = 1'b1;                    // must be ignored outside DONE
        for (int k = 1; k < NIB; k++) begin
            chk({tag, ".out_valid_add"}, 32'(out_valid), 32'd0);
            chk({tag, ".in_ready_add"}, 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);                      // NIB edges after accept
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".hold_sum"}, 32'(sum), 32'(es));
            chk({tag, ".hold_cout"}, 32'(cout), 32'(ec));
            chk({tag, ".hold_ovf"}, 32'(ovf), 32'(eo));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        run_op("t4", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 3);

        // Back-to-back with in_valid held high throughout
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'hF0F0;
        cin = 1'b0;
        @(negedge clk);                      // first set accepted
        a = 16'h00FF;
        b = 16'h0001;
        cin = 1'b1;
        for (int k = 1; k < NIB; k++) @(negedge clk);
        @(negedge clk);
        chk("t5.first_valid", 32'(out_valid), 32'd1);
        chk("t5.first_sum", 32'(sum), 32'h0000FFFF);
        chk("t5.first_cout", 32'(cout), 32'd0);
        chk("t5.first_ovf", 32'(ovf), 32'd0);
        chk("t5.no_accept_in_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);                      // drained, back in IDLE, not yet accepted
        out_ready = 1'b0;
        chk("t5.idle_after_drain", 32'(in_ready), 32'd1);
        chk("t5.valid_low", 32'(out_valid), 32'd0);
        @(negedge clk);                      // second set accepted
        in_valid = 1'b0;
        chk("t5.second_busy", 32'(in_ready), 32'd0);
        for (int k = 1; k < NIB; k++) @(negedge clk);
        @(negedge clk);
        chk("t5.second_valid", 32'(out_valid), 32'd1);
        chk("t5.second_sum", 32'(sum), 32'h00000101);
        chk("t5.second_cout", 32'(cout), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5.drained", 32'(in_ready), 32'd1);

        // Reset during the second ADD cycle
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b0;
        @(negedge clk);                      // accepted
        in_valid = 1'b0;
        @(negedge clk);                      // first nibble done, second ADD cycle now
        rst = 1'b1;
        #1;
        chk("t6.rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6.rst_sum", 32'(sum), 32'd0);
        chk("t6.rst_cout", 32'(cout), 32'd0);
        chk("t6.rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NIB + 1; k++) begin
            @(negedge clk);
            chk("t6.no_stale_valid", 32'(out_valid), 32'd0);
        end
        chk("t6.in_ready", 32'(in_ready), 32'd1);
        run_op("t6b", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Adds two WIDTH-bit operands one 4-bit nibble per clock, LSB nibble first, through a single CLA_adder slice.
- The carry is held in a register between nibbles.
- Sits directly around CLA_adder: it feeds the slice's A/B/Cin each cycle and collects its sum/Cout into the result word.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths where a full-width CLA costs too much area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NIB, WIDTH/4, derived localparam: number of nibble cycles per operation

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to the least-significant nibble
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
sum  output  WIDTH  A+B+cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (asynchronous assert, synchronous release) forces these values:
  - state=IDLE, in_ready=1, out_valid=0;
  - sum=0, cout=0, ovf=0;
  - operand shift registers, carry register and nibble counter all cleared.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, cin, a[WIDTH-1], b[WIDTH-1]; clear the counter; go to ADD.
- ADD:
  - in_ready=0, out_valid=0.
  - Each cycle the slice sees a_sh[3:0], b_sh[3:0] and carry_q.
  - The slice sum nibble shifts into the result register from the top.
  - carry_q <= Cout; a_sh and b_sh shift right by 4; counter increments.
  - After the NIB-th nibble go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are stable and held until out_ready=1.
  - On out_valid&&out_ready go to IDLE.
- Latency and throughput:
  - Handshake accepted at edge 0 → out_valid=1 after edge NIB (4 cycles for WIDTH=16).
  - Peak throughput: one operation per NIB+2 cycles.
- No same-cycle result-drain and new accept: in_ready rises in the cycle after the drain.
- Result flag rules:
  - cout = carry_q after the last nibble.
  - ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb).
- Carry wraps naturally: all-ones + 1 gives sum=0, cout=1.
- cin only affects nibble 0; later nibbles use carry_q.
- Outputs remain unchanged outside DONE. Results are only valid while out_valid=1; the bench must not sample them otherwise.
- Changes on a/b/cin while not accepting are ignored, as are changes during ADD or DONE.
- in_valid held high in DONE is not accepted until the block returns to IDLE.
- Reset mid-operation (ADD or DONE) discards the operation immediately: reset values apply and no out_valid pulse is produced.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, ADD=2'd1, DONE=2'd2;
  - NIBBLE_W=4.
- One sub-module: the existing CLA_adder (ports A, B, Cin, sum, Cout), instantiated once.
- FSM, counter, shift registers and flag logic live in nibble_serial_adder.

Test Plan:
1. WIDTH=16: a=16'h1234, b=16'h1111, cin=0 → sum=16'h2345, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
2. a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, ovf=0 (carry ripples through all four nibbles via carry_q).
3. a=16'h7FFF, b=16'h0001, cin=0 → sum=16'h8000, cout=0, ovf=1. Also a=16'h8000, b=16'h8000, cin=0 → sum=16'h0000, cout=1, ovf=1.
4. a=16'hFFFF, b=16'hFFFF, cin=1 → sum=16'hFFFF, cout=1, ovf=0; out_ready held low 3 cycles → outputs stable, in_ready=0 throughout; out_ready=1 → IDLE next cycle, in_ready=1.
5. Back-to-back: in_valid held high with two operand sets (16'h0F0F+16'hF0F0, cin=0 → 16'hFFFF; then 16'h00FF+16'h0001, cin=1 → 16'h0101). Second set accepted only in the cycle after the first drains; both results correct.
6. Reset asserted during the 2nd ADD cycle of 16'h1234+16'h4321:
   - immediately: out_valid=0, sum=0, cout=0, ovf=0;
   - after release: in_ready=1;
   - a following 16'h0005+16'h0003, cin=0 → 16'h0008, unaffected by the aborted operation.
